// File: rtl/duck_sprite_scheduler.sv
// Shared duck sprite ROM scheduler: per-pixel priority hit, animation
// stepping and a two-stage pipeline to the palette/colour mux.
module duck_sprite_scheduler #(
    parameter int NUM_DUCKS   = 4,
    parameter int SPR_W       = 64,
    parameter int SPR_H       = 64,
    parameter int ANIM_FRAMES = 2,
    parameter int FRAME_DIV   = 8,
    parameter int ADDR_W      = 13
) (
    input  logic                         vga_clk,
    input  logic                         reset_n,
    input  logic [9:0]                   DrawX,
    input  logic [9:0]                   DrawY,
    input  logic                         blank,
    input  logic                         frame_start,
    input  logic [NUM_DUCKS*10-1:0]      duck_x,
    input  logic [NUM_DUCKS*10-1:0]      duck_y,
    input  logic [NUM_DUCKS-1:0]         duck_active,
    output logic [ADDR_W-1:0]            rom_address,
    input  logic [3:0]                   rom_q,
    output logic [3:0]                   pixel_index,
    output logic                         pixel_valid,
    output logic [$clog2(NUM_DUCKS)-1:0] hit_id
);

    localparam int ID_W = $clog2(NUM_DUCKS);
    localparam int XW   = $clog2(SPR_W);
    localparam int YW   = $clog2(SPR_H);
    localparam int FW   = (ANIM_FRAMES > 1) ? $clog2(ANIM_FRAMES) : 1;
    localparam int DW   = (FRAME_DIV > 1) ? $clog2(FRAME_DIV) : 1;

    logic [9:0]           sx [NUM_DUCKS];
    logic [9:0]           sy [NUM_DUCKS];
    logic [NUM_DUCKS-1:0] sact;
    logic [FW-1:0]        anim_frame;
    logic [DW-1:0]        div_cnt;

    logic [NUM_DUCKS-1:0] hit_vec;
    logic                 any_hit;
    logic [ID_W-1:0]      win;
    logic [XW-1:0]        ox;
    logic [YW-1:0]        oy;
    logic [ADDR_W-1:0]    addr_next;

    logic                 hit1;
    logic [ID_W-1:0]      id1;
    logic                 blank1;

    // Positions are only sampled at frame_start so a frame never tears.
    always_ff @(posedge vga_clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < NUM_DUCKS; i++) begin
                sx[i] <= '0;
                sy[i] <= '0;
            end
            sact       <= '0;
            anim_frame <= '0;
            div_cnt    <= '0;
        end else if (frame_start) begin
            for (int i = 0; i < NUM_DUCKS; i++) begin
                sx[i] <= duck_x[10*i +: 10];
                sy[i] <= duck_y[10*i +: 10];
            end
            sact <= duck_active;
            if (div_cnt == DW'(FRAME_DIV - 1)) begin
                div_cnt <= '0;
                if (anim_frame == FW'(ANIM_FRAMES - 1))
                    anim_frame <= '0;
                else
                    anim_frame <= anim_frame + FW'(1);
            end else begin
                div_cnt <= div_cnt + DW'(1);
            end
        end
    end

    // 11-bit compares keep sprites from wrapping past the screen edge.
    always_comb begin
        hit_vec = '0;
        for (int i = 0; i < NUM_DUCKS; i++) begin
            hit_vec[i] = sact[i]
                && ({1'b0, DrawX} >= {1'b0, sx[i]})
                && ({1'b0, DrawX} <  {1'b0, sx[i]} + 11'(SPR_W))
                && ({1'b0, DrawY} >= {1'b0, sy[i]})
                && ({1'b0, DrawY} <  {1'b0, sy[i]} + 11'(SPR_H));
        end
    end

    always_comb begin
        any_hit = |hit_vec;
        win     = '0;
        ox      = '0;
        oy      = '0;
        for (int i = NUM_DUCKS - 1; i >= 0; i--) begin
            if (hit_vec[i]) begin
                win = ID_W'(i);
                ox  = XW'(DrawX - sx[i]);
                oy  = YW'(DrawY - sy[i]);
            end
        end
        addr_next = (ADDR_W'(anim_frame) << (XW + YW))
                  | (ADDR_W'(oy) << XW)
                  | ADDR_W'(ox);
    end

    always_ff @(posedge vga_clk or negedge reset_n) begin
        if (!reset_n) begin
            rom_address <= '0;
            hit1        <= 1'b0;
            id1         <= '0;
            blank1      <= 1'b0;
            pixel_index <= '0;
            pixel_valid <= 1'b0;
            hit_id      <= '0;
        end else begin
            if (any_hit)
                rom_address <= addr_next;
            hit1        <= any_hit;
            id1         <= win;
            blank1      <= blank;
            pixel_index <= rom_q;
            hit_id      <= id1;
            // Index 0 is transparent and does not reveal lower ducks.
            pixel_valid <= hit1 && blank1 && (rom_q != 4'd0);
        end
    end

endmodule

// File: tb/tb_duck_sprite_scheduler.sv
// Bench for duck_sprite_scheduler: vector table plus hand sequences,
// expected results queued at drive time and compared at the outputs.
module tb_duck_sprite_scheduler;

    logic        vga_clk = 1'b0;
    logic        reset_n = 1'b0;
    logic [9:0]  DrawX = '0;
    logic [9:0]  DrawY = '0;
    logic        blank = 1'b0;
    logic        frame_start = 1'b0;
    logic [39:0] duck_x = '0;
    logic [39:0] duck_y = '0;
    logic [3:0]  duck_active = '0;
    logic [12:0] rom_address;
    logic [3:0]  rom_q = '0;
    logic [3:0]  pixel_index;
    logic        pixel_valid;
    logic [1:0]  hit_id;

    duck_sprite_scheduler dut (
        .vga_clk     (vga_clk),
        .reset_n     (reset_n),
        .DrawX       (DrawX),
        .DrawY       (DrawY),
        .blank       (blank),
        .frame_start (frame_start),
        .duck_x      (duck_x),
        .duck_y      (duck_y),
        .duck_active (duck_active),
        .rom_address (rom_address),
        .rom_q       (rom_q),
        .pixel_index (pixel_index),
        .pixel_valid (pixel_valid),
        .hit_id      (hit_id)
    );

    always #5 vga_clk = ~vga_clk;

    logic [3:0] mem [8192];

    always @(negedge vga_clk) rom_q <= mem[rom_address];

    typedef struct {
        logic [12:0] addr;
        logic        hit;
        logic [1:0]  id;
        logic        bl;
    } sb_t;

    typedef struct {
        int   x;
        int   y;
        logic bl;
        logic hit;
        int   id;
        int   addr;
    } vec_t;

    sb_t  sb [$];
    vec_t tbl [15];
    int   checks = 0;
    int   errors = 0;
    int   last_exp = 0;
    int   pulses = 0;

    task automatic chk(string nm, int act, int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    task automatic set_duck(int i, int x, int y, logic a);
        duck_x[i*10 +: 10] = 10'(x);
        duck_y[i*10 +: 10] = 10'(y);
        duck_active[i] = a;
    endtask

    task automatic step(int x, int y, logic bl, logic fs,
                        logic hit, int id, int addr);
        sb_t e;
        sb_t p;
        DrawX = 10'(x);
        DrawY = 10'(y);
        blank = bl;
        frame_start = fs;
        e.addr = hit ? 13'(addr) : 13'(last_exp);
        last_exp = int'(e.addr);
        e.hit = hit;
        e.id = 2'(id);
        e.bl = bl;
        sb.push_back(e);
        @(posedge vga_clk);
        #1;
        frame_start = 1'b0;
        if (fs) pulses++;
        chk("rom_address", int'(rom_address), int'(sb[$].addr));
        if (sb.size() > 1) begin
            p = sb.pop_front();
            chk("pixel_valid", int'(pixel_valid),
                int'(p.hit && p.bl && (mem[p.addr] != 4'd0)));
            if (p.hit) begin
                chk("hit_id", int'(hit_id), int'(p.id));
                chk("pixel_index", int'(pixel_index), int'(mem[p.addr]));
            end
        end
    endtask

    task automatic pulse();
        step(0, 0, 1'b0, 1'b1, 1'b0, 0, 0);
    endtask

    task automatic flush();
        step(0, 0, 1'b0, 1'b0, 1'b0, 0, 0);
    endtask

    initial begin
        for (int a = 0; a < 8192; a++) mem[a] = 4'((a * 7 + 3) & 15);
        mem[0]   = 4'd5;
        mem[660] = 4'd0;

        tbl[0]  = '{100,  50, 1'b1, 1'b1, 0, 0};
        tbl[1]  = '{163, 113, 1'b1, 1'b1, 0, 4095};
        tbl[2]  = '{164,  50, 1'b1, 1'b0, 0, 0};
        tbl[3]  = '{120,  60, 1'b1, 1'b1, 0, 660};
        tbl[4]  = '{170,  60, 1'b1, 1'b1, 2, 380};
        tbl[5]  = '{300, 200, 1'b1, 1'b1, 1, 0};
        tbl[6]  = '{639, 400, 1'b1, 1'b1, 3, 39};
        tbl[7]  = '{ 27, 400, 1'b1, 1'b0, 0, 0};
        tbl[8]  = '{  0, 400, 1'b1, 1'b0, 0, 0};
        tbl[9]  = '{100,  50, 1'b0, 1'b1, 0, 0};
        tbl[10] = '{ 99,  50, 1'b1, 1'b0, 0, 0};
        tbl[11] = '{100,  49, 1'b1, 1'b0, 0, 0};
        tbl[12] = '{100, 113, 1'b1, 1'b1, 0, 4032};
        tbl[13] = '{163,  50, 1'b1, 1'b1, 0, 63};
        tbl[14] = '{173, 118, 1'b1, 1'b1, 2, 4095};

        repeat (2) @(posedge vga_clk);
        #1;
        chk("reset rom_address", int'(rom_address), 0);
        chk("reset pixel_valid", int'(pixel_valid), 0);
        chk("reset pixel_index", int'(pixel_index), 0);
        chk("reset hit_id", int'(hit_id), 0);
        reset_n = 1'b1;

        set_duck(0, 100,  50, 1'b1);
        set_duck(1, 300, 200, 1'b1);
        set_duck(2, 110,  55, 1'b1);
        set_duck(3, 600, 400, 1'b1);

        // Inputs are not seen until a frame_start latches them.
        step(100, 50, 1'b1, 1'b0, 1'b0, 0, 0);
        pulse();

        for (int i = 0; i < 15; i++)
            step(tbl[i].x, tbl[i].y, tbl[i].bl, 1'b0,
                 tbl[i].hit, tbl[i].id, tbl[i].addr);
        flush();

        // Animation stepping every eight frame_start pulses.
        while (pulses % 16 != 7) pulse();
        step(100, 50, 1'b1, 1'b0, 1'b1, 0, 0);
        pulse();
        step(100, 50, 1'b1, 1'b0, 1'b1, 0, 4096);
        step(163, 113, 1'b1, 1'b0, 1'b1, 0, 8191);
        while (pulses % 16 != 0) pulse();
        step(100, 50, 1'b1, 1'b0, 1'b1, 0, 0);
        flush();

        // Mid-frame move takes effect only after the next frame_start.
        set_duck(0, 200, 50, 1'b1);
        step(100, 50, 1'b1, 1'b0, 1'b1, 0, 0);
        step(200, 50, 1'b1, 1'b0, 1'b0, 0, 0);
        step(200, 50, 1'b1, 1'b1, 1'b0, 0, 0);
        step(200, 50, 1'b1, 1'b0, 1'b1, 0, 0);
        step(100, 50, 1'b1, 1'b0, 1'b0, 0, 0);
        flush();

        // Asynchronous reset in the middle of a line.
        step(263, 113, 1'b1, 1'b0, 1'b1, 0, 4095);
        step(200, 50, 1'b1, 1'b0, 1'b1, 0, 0);
        #2;
        reset_n = 1'b0;
        #1;
        chk("midreset rom_address", int'(rom_address), 0);
        chk("midreset pixel_valid", int'(pixel_valid), 0);
        chk("midreset pixel_index", int'(pixel_index), 0);
        chk("midreset hit_id", int'(hit_id), 0);
        @(posedge vga_clk);
        #1;
        reset_n = 1'b1;
        sb.delete();
        last_exp = 0;
        pulses = 0;
        step(200, 50, 1'b1, 1'b0, 1'b0, 0, 0);
        step(200, 50, 1'b1, 1'b0, 1'b0, 0, 0);
        pulse();
        step(200, 50, 1'b1, 1'b0, 1'b1, 0, 0);
        flush();
        flush();

        $display("Simulation finished: %0d checks, %0d errors",
                 checks, errors);
        $finish;
    end

endmodule
